// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the data-memory port arbiter.
// The state and owner enums are used by the arbiter top and its priority sub-block.
package mem_arb_pkg;

   localparam int unsigned ADDR_W_DEF       = 4;
   localparam int unsigned DATA_W_DEF       = 8;
   localparam int unsigned STARVE_LIMIT_DEF = 4;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } arb_state_t;

   typedef enum logic {
      OWN_CPU,
      OWN_DBG
   } arb_owner_t;

   // Counter width able to hold the value limit (at least one bit).
   function automatic int unsigned cnt_width(input int unsigned limit);
      return (limit < 1) ? 1 : $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Winner selection for the memory port: CPU has fixed priority over DBG.
// With MEM_ARB_STARVE_GUARD_EN defined, DBG is forced to win after STARVE_LIMIT straight losses.
module mem_arb_prio
   import mem_arb_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       decide,
   input  logic       cpu_req,
   input  logic       dbg_req,
   output logic       any_req,
   output arb_owner_t winner
);

   assign any_req = cpu_req | dbg_req;

`ifdef MEM_ARB_STARVE_GUARD_EN
   localparam int unsigned CntW = cnt_width(STARVE_LIMIT);

   logic [CntW-1:0] starve_q, starve_d;
   logic            force_dbg;

   assign force_dbg = dbg_req && (starve_q == CntW'(STARVE_LIMIT));

   always_comb begin
      winner = OWN_CPU;
      if (dbg_req && (force_dbg || !cpu_req)) begin
         winner = OWN_DBG;
      end
   end

   // Counts only decisions DBG actually contested and lost.
   always_comb begin
      starve_d = starve_q;
      if (decide && dbg_req) begin
         if (winner == OWN_DBG) begin
            starve_d = '0;
         end else begin
            starve_d = starve_q + CntW'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         starve_q <= '0;
      end else begin
         starve_q <= starve_d;
      end
   end
`else
   localparam int unsigned unused_limit = STARVE_LIMIT;

   logic unused_ok;
   assign unused_ok = ^{clock, reset, decide};

   always_comb begin
      winner = OWN_CPU;
      if (dbg_req && !cpu_req) begin
         winner = OWN_DBG;
      end
   end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises CPU and DBG accesses onto the single-port data memory and routes read data back.
// Optional starvation guard in mem_arb_prio is enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W       = ADDR_W_DEF,
   parameter int unsigned DATA_W       = DATA_W_DEF,
   parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic              dbg_gnt,
   output logic              dbg_rvalid,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              owner
);

   arb_state_t        state_q, state_d;
   arb_owner_t        owner_q, owner_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;

   logic       any_req;
   arb_owner_t winner;

   mem_arb_prio #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_prio (
      .clock   (clock),
      .reset   (reset),
      .decide  (state_q == IDLE),
      .cpu_req (cpu_req),
      .dbg_req (dbg_req),
      .any_req (any_req),
      .winner  (winner)
   );

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      cpu_rdata_d = cpu_rdata_q;
      dbg_rdata_d = dbg_rdata_q;
      unique case (state_q)
         IDLE: begin
            if (any_req) begin
               owner_d = winner;
               if (winner == OWN_DBG) begin
                  we_d    = dbg_we;
                  addr_d  = dbg_addr;
                  wdata_d = dbg_wdata;
               end else begin
                  we_d    = cpu_we;
                  addr_d  = cpu_addr;
                  wdata_d = cpu_wdata;
               end
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            state_d = we_q ? IDLE : RESP;
         end
         RESP: begin
            if (owner_q == OWN_DBG) begin
               dbg_rdata_d = mem_rdata;
            end else begin
               cpu_rdata_d = mem_rdata;
            end
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         owner_q     <= OWN_CPU;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         cpu_rdata_q <= '0;
         dbg_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         cpu_rdata_q <= cpu_rdata_d;
         dbg_rdata_q <= dbg_rdata_d;
      end
   end

   // Outputs are forced low while reset is held so an abandoned access never pulses gnt/rvalid.
   always_comb begin
      cpu_gnt    = 1'b0;
      cpu_rvalid = 1'b0;
      cpu_rdata  = '0;
      dbg_gnt    = 1'b0;
      dbg_rvalid = 1'b0;
      dbg_rdata  = '0;
      mem_en     = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      busy       = 1'b0;
      owner      = 1'b0;
      if (!reset) begin
         busy      = (state_q != IDLE);
         owner     = busy && (owner_q == OWN_DBG);
         cpu_rdata = cpu_rdata_q;
         dbg_rdata = dbg_rdata_q;
         if (state_q == ACCESS) begin
            mem_en    = 1'b1;
            mem_we    = we_q;
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
            cpu_gnt   = (owner_q == OWN_CPU);
            dbg_gnt   = (owner_q == OWN_DBG);
         end
         // Read data is visible on the rvalid cycle itself, then held by the register.
         if (state_q == RESP) begin
            if (owner_q == OWN_DBG) begin
               dbg_rvalid = 1'b1;
               dbg_rdata  = mem_rdata;
            end else begin
               cpu_rvalid = 1'b1;
               cpu_rdata  = mem_rdata;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed cases plus randomized two-requester traffic
// checked every cycle against a transaction-timeline model with its own shadow memory.
module tb_mem_port_arbiter;

   localparam int unsigned AW    = 4;
   localparam int unsigned DW    = 8;
   localparam int unsigned LIMIT = 4;

   localparam logic [DW-1:0] INIT [16] = '{
      8'h77, 8'h65, 8'h3c, 8'h91, 8'h02, 8'hd4, 8'h18, 8'hab,
      8'h40, 8'hee, 8'h07, 8'h5f, 8'hc2, 8'h33, 8'h86, 8'h1d
   };

   logic          clock = 1'b0;
   logic          reset;
   logic          cpu_req, cpu_we, dbg_req, dbg_we;
   logic [AW-1:0] cpu_addr, dbg_addr;
   logic [DW-1:0] cpu_wdata, dbg_wdata;
   logic          cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
   logic [DW-1:0] cpu_rdata, dbg_rdata;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata = '0;
   logic          busy, owner;

   int checks   = 0;
   int failures = 0;

   always #5 clock = ~clock;

   mem_port_arbiter #(
      .ADDR_W       (AW),
      .DATA_W       (DW),
      .STARVE_LIMIT (LIMIT)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_gnt    (cpu_gnt),
      .cpu_rvalid (cpu_rvalid),
      .cpu_rdata  (cpu_rdata),
      .dbg_req    (dbg_req),
      .dbg_we     (dbg_we),
      .dbg_addr   (dbg_addr),
      .dbg_wdata  (dbg_wdata),
      .dbg_gnt    (dbg_gnt),
      .dbg_rvalid (dbg_rvalid),
      .dbg_rdata  (dbg_rdata),
      .mem_en     (mem_en),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .busy       (busy),
      .owner      (owner)
   );

   // Registered-read memory array attached to the port.
   logic [DW-1:0] mem [16];
   initial for (int i = 0; i < 16; i++) mem[i] = INIT[i];
   always @(posedge clock) begin
      if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         else        mem_rdata     <= mem[mem_addr];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Reference model: each accepted request is a transaction decided at cycle d,
   // accessing memory at d+1 and (for reads) returning data at d+2; the port is free again after.
   logic [DW-1:0] shadow [16];
   initial for (int i = 0; i < 16; i++) shadow[i] = INIT[i];

   bit            m_valid = 0, m_own = 0, m_we = 0;
   logic [AW-1:0] m_addr = '0;
   logic [DW-1:0] m_wdata = '0, m_rd = '0, m_cpu_rd = '0, m_dbg_rd = '0;
   int            m_dcyc = 0, m_starve = 0, cyc = 0;

   always @(negedge clock) begin
      bit            e_busy, e_owner, e_men, e_mwe, e_cg, e_dg, e_cv, e_dv, last;
      logic [AW-1:0] e_ma;
      logic [DW-1:0] e_mwd;
      e_busy = 0; e_owner = 0; e_men = 0; e_mwe = 0;
      e_cg = 0; e_dg = 0; e_cv = 0; e_dv = 0; e_ma = '0; e_mwd = '0;
      if (reset) begin
         m_valid = 0; m_cpu_rd = '0; m_dbg_rd = '0; m_starve = 0;
      end else begin
         if (m_valid && cyc == m_dcyc + 1) begin
            e_men = 1; e_mwe = m_we; e_ma = m_addr; e_mwd = m_wdata;
            if (m_own) e_dg = 1; else e_cg = 1;
            if (m_we) shadow[m_addr] = m_wdata;
            else      m_rd = shadow[m_addr];
         end
         if (m_valid && !m_we && cyc == m_dcyc + 2) begin
            if (m_own) begin e_dv = 1; m_dbg_rd = m_rd; end
            else       begin e_cv = 1; m_cpu_rd = m_rd; end
         end
         last    = m_valid && cyc <= m_dcyc + (m_we ? 1 : 2);
         e_busy  = last && cyc > m_dcyc;
         e_owner = e_busy && m_own;
      end
      check("busy", busy, e_busy);
      check("owner", owner, e_owner);
      check("mem_en", mem_en, e_men);
      if (e_men || reset) begin
         check("mem_we", mem_we, e_mwe);
         check("mem_addr", mem_addr, e_ma);
         check("mem_wdata", mem_wdata, e_mwd);
      end
      check("cpu_gnt", cpu_gnt, e_cg);
      check("dbg_gnt", dbg_gnt, e_dg);
      check("cpu_rvalid", cpu_rvalid, e_cv);
      check("dbg_rvalid", dbg_rvalid, e_dv);
      check("cpu_rdata", cpu_rdata, m_cpu_rd);
      check("dbg_rdata", dbg_rdata, m_dbg_rd);
      if (!reset && !last) begin
         m_valid = 0;
         if (cpu_req || dbg_req) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
            m_own = dbg_req && (m_starve == LIMIT || !cpu_req);
            if (m_own) m_starve = 0;
            else if (dbg_req) m_starve++;
`else
            m_own = dbg_req && !cpu_req;
`endif
            m_valid = 1; m_dcyc = cyc;
            m_we    = m_own ? dbg_we : cpu_we;
            m_addr  = m_own ? dbg_addr : cpu_addr;
            m_wdata = m_own ? dbg_wdata : cpu_wdata;
         end
      end
      cyc++;
   end

   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   int seq [64];
   int n;
   bit cpu_g, dbg_g, saw_dbg;

   initial begin
      reset = 1; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
      dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
      next_cycle(); settle();
      check("reset_busy", busy, 0);
      check("reset_mem_en", mem_en, 0);
      check("reset_cpu_rdata", cpu_rdata, 0);
      check("reset_dbg_rdata", dbg_rdata, 0);
      next_cycle(); reset = 0; settle();

      // Single CPU read of addr 4
      next_cycle(); cpu_req = 1; cpu_we = 0; cpu_addr = 4; cpu_wdata = 8'hff; settle();
      check("t1_no_gnt_c0", cpu_gnt, 0);
      next_cycle(); settle();
      check("t1_cpu_gnt", cpu_gnt, 1);
      check("t1_mem_addr", mem_addr, 4);
      check("t1_dbg_gnt", dbg_gnt, 0);
      next_cycle(); cpu_req = 0; settle();
      check("t1_cpu_rvalid", cpu_rvalid, 1);
      check("t1_cpu_rdata", cpu_rdata, 8'h02);
      check("t1_dbg_rvalid", dbg_rvalid, 0);

      // Simultaneous reads: CPU first, then DBG
      next_cycle(); cpu_req = 1; cpu_addr = 0; dbg_req = 1; dbg_we = 0; dbg_addr = 1; settle();
      next_cycle(); settle();
      check("t2_cpu_gnt", cpu_gnt, 1);
      check("t2_dbg_gnt_c1", dbg_gnt, 0);
      next_cycle(); cpu_req = 0; settle();
      check("t2_cpu_rdata", cpu_rdata, 8'h77);
      next_cycle(); settle();
      next_cycle(); settle();
      check("t2_dbg_gnt", dbg_gnt, 1);
      check("t2_owner", owner, 1);
      next_cycle(); dbg_req = 0; settle();
      check("t2_dbg_rvalid", dbg_rvalid, 1);
      check("t2_dbg_rdata", dbg_rdata, 8'h65);

      // CPU write 0x5A to addr 9, then DBG reads it back
      next_cycle(); cpu_req = 1; cpu_we = 1; cpu_addr = 9; cpu_wdata = 8'h5a; settle();
      next_cycle(); settle();
      check("t3_mem_we", mem_we, 1);
      check("t3_mem_wdata", mem_wdata, 8'h5a);
      next_cycle(); cpu_req = 0; cpu_we = 0; dbg_req = 1; dbg_addr = 9; settle();
      check("t3_idle_after_write", busy, 0);
      next_cycle(); settle();
      next_cycle(); dbg_req = 0; settle();
      check("t3_dbg_rdata", dbg_rdata, 8'h5a);
      check("t3_cpu_rdata_held", cpu_rdata, 8'h77);

      // Starvation with both requests held
      next_cycle(); reset = 1;
      next_cycle(); reset = 0;
      next_cycle(); cpu_req = 1; cpu_addr = 3; dbg_req = 1; dbg_addr = 5;
      n = 0; saw_dbg = 0;
      for (int k = 0; k < 400 && n < 50; k++) begin
         settle();
         if (cpu_gnt) begin seq[n] = 0; n++; end
         if (dbg_gnt) begin seq[n] = 1; n++; saw_dbg = 1; end
         next_cycle();
      end
      check("t4_decisions", n, 50);
`ifdef MEM_ARB_STARVE_GUARD_EN
      for (int i = 0; i < 4; i++) check("t4_cpu_first", seq[i], 0);
      check("t4_dbg_fifth", seq[4], 1);
      check("t4_cpu_resumes", seq[5], 0);
`else
      check("t4_dbg_starved", saw_dbg, 0);
`endif
      cpu_req = 0; dbg_req = 0;
      repeat (4) next_cycle();

      // Reset during RESP of a DBG read
      dbg_req = 1; dbg_we = 0; dbg_addr = 2; settle();
      next_cycle(); settle();
      check("t5_dbg_gnt", dbg_gnt, 1);
      next_cycle(); dbg_req = 0; reset = 1; settle();
      check("t5_no_rvalid", dbg_rvalid, 0);
      next_cycle(); reset = 0; settle();
      check("t5_busy0", busy, 0);
      check("t5_dbg_rdata0", dbg_rdata, 0);
      check("t5_cpu_rdata0", cpu_rdata, 0);
      check("t5_dbg_rvalid0", dbg_rvalid, 0);
      next_cycle(); cpu_req = 1; cpu_we = 0; cpu_addr = 10; settle();
      next_cycle(); settle();
      check("t5_cpu_gnt", cpu_gnt, 1);
      next_cycle(); cpu_req = 0; settle();
      check("t5_cpu_rvalid", cpu_rvalid, 1);
      check("t5_cpu_rdata", cpu_rdata, 8'h07);

      // Randomized traffic with occasional reset
      cpu_g = 0; dbg_g = 0;
      for (int k = 0; k < 1500; k++) begin
         next_cycle();
         reset = ($urandom_range(0, 79) == 0);
         if (!cpu_req || cpu_g) begin
            cpu_req   = ($urandom_range(0, 3) != 0);
            cpu_we    = 1'($urandom_range(0, 1));
            cpu_addr  = AW'($urandom);
            cpu_wdata = DW'($urandom);
         end
         if (!dbg_req || dbg_g) begin
            dbg_req   = ($urandom_range(0, 3) != 0);
            dbg_we    = 1'($urandom_range(0, 1));
            dbg_addr  = AW'($urandom);
            dbg_wdata = DW'($urandom);
         end
         settle();
         cpu_g = cpu_gnt;
         dbg_g = dbg_gnt;
      end
      next_cycle(); reset = 0; cpu_req = 0; dbg_req = 0;
      repeat (4) next_cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port 16x8 data memory between two requesters: the microprogrammed multiplier control unit (CPU port) and the button/7-segment memory inspector (DBG port).
- Serialises their accesses, drives the memory port, and returns read data on the port that issued the read.
- Sits between both requesters and the memory array. It replaces the direct memory indexing each requester would otherwise do.

Parameters:
- ADDR_W, 4, memory address width (depth 2**ADDR_W).
- DATA_W, 8, memory word width.
- STARVE_LIMIT, 4, number of consecutive DBG losses before DBG is forced to win (used only with the optional feature).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- cpu_req  in  1  CPU access request; held until cpu_gnt.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_gnt  out  1  one-cycle pulse; CPU access performed this cycle.
- cpu_rvalid  out  1  one-cycle pulse; cpu_rdata is valid.
- cpu_rdata  out  DATA_W  CPU read data; held until the next CPU read response.
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_gnt, dbg_rvalid, dbg_rdata: identical semantics to the CPU set, for the inspector.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, registered by the memory, valid the cycle after mem_en with mem_we=0.
- busy  out  1  1 whenever the state is not IDLE.
- owner  out  1  0 = CPU, 1 = DBG; valid while busy, 0 otherwise.

Behaviour:
- Reset: synchronous, active-high; clock is `clock`.
  - State goes to IDLE.
  - All outputs go to 0, including rdata registers, mem_*, busy and owner.
  - The starvation counter clears.
- State machine: IDLE -> ACCESS -> (RESP if read) -> IDLE.
- IDLE:
  - If any request is high, choose a winner.
  - Latch the winner's we, addr and wdata, plus owner.
  - Go to ACCESS.
  - If no request is high, stay in IDLE with mem_en=0.
- ACCESS (exactly 1 cycle):
  - mem_en=1; mem_we, mem_addr and mem_wdata come from the latched request.
  - The winner's gnt pulses.
  - Next state is RESP for a read, IDLE for a write.
- RESP (exactly 1 cycle):
  - The owner's rdata register loads mem_rdata.
  - The owner's rvalid pulses this cycle; the rdata register holds the loaded value from this cycle onward.
  - Go to IDLE.
- Latency, from req high in IDLE at cycle 0:
  - gnt in cycle 1.
  - rvalid in cycle 2 (reads only).
  - Throughput: one write per 2 cycles, one read per 3 cycles.
- Handshake rules:
  - A requester keeps req, we, addr and wdata stable until it sees gnt.
  - In the cycle after gnt it either drops req or presents a new request.
  - Requests are sampled only in IDLE. Changes while waiting are unsupported.
- Arbitration: strict fixed priority, CPU over DBG. When both requests are high, CPU wins.
- Requests arriving during ACCESS or RESP wait for the next IDLE decision. Nothing is lost.
- The non-owner's gnt and rvalid stay 0, and its rdata is unchanged.
- Reset mid-operation: the in-flight access is abandoned.
  - No gnt or rvalid is issued after reset.
  - A write already strobed in ACCESS has completed.
  - The first request after reset is serviced normally.
- Addresses wrap naturally at 2**ADDR_W. There is no out-of-range check.

Optional Feature:
- Macro: MEM_ARB_STARVE_GUARD_EN.
- Defined:
  - A counter of width clog2(STARVE_LIMIT+1) increments at each IDLE decision where dbg_req=1 and CPU wins.
  - When the counter equals STARVE_LIMIT and dbg_req=1, DBG wins that decision regardless of cpu_req, and the counter clears.
  - The counter also clears whenever DBG wins.
- Not defined: strict CPU priority. The counter logic is absent and DBG can starve indefinitely.

Decomposition:
- Package mem_arb_pkg:
  - ADDR_W/DATA_W defaults.
  - State enum arb_state_t {IDLE, ACCESS, RESP}.
  - Owner enum arb_owner_t {OWN_CPU, OWN_DBG}.
- Sub-module mem_arb_prio: winner selection plus the starvation counter (the counter only under the macro). The top level holds the FSM, request latch and rdata registers.

Test Plan:
- Single CPU read: mem[4]=0x02; cpu_req/addr=4/we=0 at cycle 0 -> cpu_gnt in cycle 1 with mem_addr=4, cpu_rvalid in cycle 2, cpu_rdata=0x02; dbg_* stays 0.
- Simultaneous reads: CPU addr 0 (0x77) and DBG addr 1 (0x65) raised together.
  - cpu_gnt in cycle 1, cpu_rvalid with 0x77 in cycle 2.
  - dbg_gnt in cycle 4, dbg_rvalid with 0x65 in cycle 5.
- Write then read: CPU writes 0x5A to addr 9 -> mem_we=1 in the gnt cycle; a subsequent DBG read of addr 9 returns 0x5A; cpu_rdata is unchanged.
- Starvation, cpu_req held high continuously and dbg_req held high:
  - With MEM_ARB_STARVE_GUARD_EN: four CPU grants, then dbg_gnt on the 5th decision, then CPU resumes.
  - Without the macro: dbg_gnt never asserts over 50 decisions.
- Reset during RESP of a DBG read: no dbg_rvalid; all outputs 0 the next cycle; a following CPU read of addr 10 returns 0x07 with normal latency.
